// File: rtl/rd_arb_pkg.sv
// Shared widths, defaults and mdata field helpers for the read-request arbiter.
package rd_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 48;
    localparam int DEF_MDATA_W = 16;
    localparam int DEF_TAG_W   = 12;
    localparam int DEF_MAX_OUT = 32;
    localparam int MDATA_MAX   = 64;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

    // Tag must already be zero-extended from TAG_W so it cannot bleed into the ID field.
    function automatic logic [MDATA_MAX-1:0] pack_mdata(input logic [MDATA_MAX-1:0] id,
                                                        input logic [MDATA_MAX-1:0] tag,
                                                        input int tag_w);
        return (id << tag_w) | tag;
    endfunction

    function automatic int unpack_id(input logic [MDATA_MAX-1:0] mdata,
                                     input int tag_w, input int id_w);
        return int'((mdata >> tag_w) & ((MDATA_MAX'(1) << id_w) - MDATA_MAX'(1)));
    endfunction

endpackage

// File: rtl/rd_req_arbiter_rr.sv
// Generic round-robin picker: first eligible requester at or above the pointer wins.
module rr_arbiter
    import rd_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W   = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   ptr
);

    logic [PTR_W-1:0] next_ptr;
    logic             found;
    int               idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (advance && !found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else       ptr <= next_ptr;
    end

endmodule

// File: rtl/rd_req_arbiter.sv
// Shares the c0Tx read-request channel among NUM_REQ ports, stamping the port ID into mdata
// and steering c0Rx responses back to the owner by that ID.
module rd_req_arbiter
    import rd_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int MDATA_W = DEF_MDATA_W,
    parameter  int TAG_W   = DEF_TAG_W,
    parameter  int MAX_OUT = DEF_MAX_OUT,
    localparam int ID_W    = id_width(NUM_REQ),
    localparam int CNT_W   = cnt_width(MAX_OUT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         port_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_grant,
    input  logic                       rd_available,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [MDATA_W-1:0]         rd_mdata,
    input  logic                       resp_valid,
    input  logic [511:0]               resp_data,
    input  logic [MDATA_W-1:0]         resp_mdata,
    output logic [NUM_REQ-1:0]         port_resp_valid,
    output logic [511:0]               port_resp_data,
    output logic [TAG_W-1:0]           port_resp_tag,
    output logic [NUM_REQ*CNT_W-1:0]   outstanding,
    output logic                       idle,
    output logic                       err
);

    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] resp_hit;
    logic [NUM_REQ-1:0] dec;
    logic [ID_W-1:0]    rr_ptr;
    logic               id_ok;
    logic               resp_to_empty;
    logic               any_cnt;
    int                 gsel;
    int                 rid;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_valid[i] && port_en[i] && (cnt[i] < CNT_W'(MAX_OUT));
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .advance  (rd_available),
        .grant    (req_grant),
        .ptr      (rr_ptr)
    );

    always_comb begin
        gsel = 0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_grant[i]) gsel = i;
    end

    // Only the ID field is decoded; pad bits above it are ignored.
    always_comb begin
        rid           = unpack_id(MDATA_MAX'(resp_mdata), TAG_W, ID_W);
        id_ok         = rid < NUM_REQ;
        resp_hit      = '0;
        dec           = '0;
        resp_to_empty = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_hit[i] = resp_valid && (rid == i);
            dec[i]      = resp_hit[i] && (cnt[i] != '0);
            if (resp_hit[i] && cnt[i] == '0) resp_to_empty = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rd_mdata <= '0;
        end else begin
            rd_en <= |req_grant;
            if (|req_grant) begin
                rd_addr  <= req_addr[gsel*ADDR_W +: ADDR_W];
                rd_mdata <= MDATA_W'(pack_mdata(MDATA_MAX'(gsel),
                                                MDATA_MAX'(req_tag[gsel*TAG_W +: TAG_W]),
                                                TAG_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_resp_valid <= '0;
            port_resp_data  <= '0;
            port_resp_tag   <= '0;
            err             <= 1'b0;
        end else begin
            port_resp_valid <= resp_hit;
            if (resp_valid && id_ok) begin
                port_resp_data <= resp_data;
                port_resp_tag  <= resp_mdata[TAG_W-1:0];
            end
            if (resp_valid && (!id_ok || resp_to_empty)) err <= 1'b1;
        end
    end

    // A simultaneous grant and response on one port cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_grant[i] && !dec[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (dec[i] && !req_grant[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        outstanding = '0;
        any_cnt     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding[i*CNT_W +: CNT_W] = cnt[i];
            if (cnt[i] != '0) any_cnt = 1'b1;
        end
        idle = !any_cnt && !rd_en;
    end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed vector table for a 4-port, MAX_OUT=2 arbiter plus hand sequences on a 3-port copy.
module tb_rd_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int MW = 16;
    localparam int TW = 12;
    localparam int CW = 2;
    localparam int N3 = 3;
    localparam int CW3 = 6;

    logic             clk;
    logic             reset;
    logic [N-1:0]     port_en, req_valid, req_grant, port_resp_valid;
    logic [N*AW-1:0]  req_addr;
    logic [N*TW-1:0]  req_tag;
    logic             rd_available, rd_en, resp_valid, idle, err;
    logic [AW-1:0]    rd_addr;
    logic [MW-1:0]    rd_mdata, resp_mdata;
    logic [511:0]     resp_data, port_resp_data;
    logic [TW-1:0]    port_resp_tag;
    logic [N*CW-1:0]  outstanding;

    logic [N3-1:0]     b_en, b_rv, b_grant, b_prv;
    logic [N3*AW-1:0]  b_addr;
    logic [N3*TW-1:0]  b_tag;
    logic              b_av, b_rd_en, b_rsp_valid, b_idle, b_err;
    logic [AW-1:0]     b_rd_addr;
    logic [MW-1:0]     b_rd_mdata, b_rsp_mdata;
    logic [511:0]      b_rsp_data, b_prd;
    logic [TW-1:0]     b_ptag;
    logic [N3*CW3-1:0] b_out;

    rd_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .MDATA_W(MW), .TAG_W(TW), .MAX_OUT(2)) u_dut (
        .clk(clk), .reset(reset), .port_en(port_en), .req_valid(req_valid),
        .req_addr(req_addr), .req_tag(req_tag), .req_grant(req_grant),
        .rd_available(rd_available), .rd_en(rd_en), .rd_addr(rd_addr), .rd_mdata(rd_mdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_mdata(resp_mdata),
        .port_resp_valid(port_resp_valid), .port_resp_data(port_resp_data),
        .port_resp_tag(port_resp_tag), .outstanding(outstanding), .idle(idle), .err(err)
    );

    rd_req_arbiter #(.NUM_REQ(N3), .ADDR_W(AW), .MDATA_W(MW), .TAG_W(TW), .MAX_OUT(32)) u_dut3 (
        .clk(clk), .reset(reset), .port_en(b_en), .req_valid(b_rv),
        .req_addr(b_addr), .req_tag(b_tag), .req_grant(b_grant),
        .rd_available(b_av), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_mdata(b_rd_mdata),
        .resp_valid(b_rsp_valid), .resp_data(b_rsp_data), .resp_mdata(b_rsp_mdata),
        .port_resp_valid(b_prv), .port_resp_data(b_prd),
        .port_resp_tag(b_ptag), .outstanding(b_out), .idle(b_idle), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  en;
        logic        av;
        logic        rsv;
        logic [15:0] rmd;
        logic [3:0]  eg;
        logic        erd;
        logic [7:0]  eout;
        logic [3:0]  eprv;
    } vec_t;

    vec_t tbl [17];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pattern(input int k);
        return {16{32'hD00D_0000 | 32'(k)}};
    endfunction

    task automatic chk_reset_state();
        chk("rst_rd_en", 512'(rd_en), 512'(0));
        chk("rst_rd_addr", 512'(rd_addr), 512'(0));
        chk("rst_rd_mdata", 512'(rd_mdata), 512'(0));
        chk("rst_prv", 512'(port_resp_valid), 512'(0));
        chk("rst_pdata", port_resp_data, 512'(0));
        chk("rst_ptag", 512'(port_resp_tag), 512'(0));
        chk("rst_outstanding", 512'(outstanding), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_idle", 512'(idle), 512'(1));
        chk("rst3_err", 512'(b_err), 512'(0));
        chk("rst3_idle", 512'(b_idle), 512'(1));
        chk("rst3_prv", 512'(b_prv), 512'(0));
    endtask

    initial begin
        int g;
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b1, 8'h01, 4'h0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b1, 8'h05, 4'h0};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0100, 1'b1, 8'h15, 4'h0};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b1000, 1'b1, 8'h55, 4'h0};
        tbl[4]  = '{4'hF, 4'hF, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h55, 4'h0};
        tbl[5]  = '{4'hF, 4'hF, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h55, 4'h0};
        tbl[6]  = '{4'hF, 4'hF, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h55, 4'h0};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b1, 8'h56, 4'h0};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b1, 8'h5A, 4'h0};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0100, 1'b1, 8'h6A, 4'h0};
        tbl[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b1000, 1'b1, 8'hAA, 4'h0};
        tbl[11] = '{4'hF, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'hAA, 4'h0};
        tbl[12] = '{4'h2, 4'hD, 1'b1, 1'b1, 16'h1055, 4'b0000, 1'b0, 8'hA6, 4'h2};
        tbl[13] = '{4'h2, 4'hF, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b1, 8'hAA, 4'h0};
        tbl[14] = '{4'h0, 4'hF, 1'b1, 1'b1, 16'h2ABC, 4'b0000, 1'b0, 8'h9A, 4'h4};
        tbl[15] = '{4'h0, 4'hF, 1'b1, 1'b1, 16'h0001, 4'b0000, 1'b0, 8'h99, 4'h1};
        tbl[16] = '{4'h1, 4'hF, 1'b1, 1'b1, 16'h0002, 4'b0001, 1'b1, 8'h99, 4'h1};

        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 48'(i + 1) << 20;
            req_tag[i*TW +: TW]  = 12'h010 + 12'(i);
        end
        for (int i = 0; i < N3; i++) begin
            b_addr[i*AW +: AW] = '0;
            b_tag[i*TW +: TW]  = '0;
        end
        port_en = '0; req_valid = '0; rd_available = 1'b0;
        resp_valid = 1'b0; resp_data = '0; resp_mdata = '0;
        b_en = '0; b_rv = '0; b_av = 1'b1;
        b_rsp_valid = 1'b0; b_rsp_data = '0; b_rsp_mdata = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_reset_state();

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            req_valid    = tbl[k].rv;
            port_en      = tbl[k].en;
            rd_available = tbl[k].av;
            resp_valid   = tbl[k].rsv;
            resp_mdata   = tbl[k].rmd;
            resp_data    = pattern(k);
            #1 chk($sformatf("grant[%0d]", k), 512'(req_grant), 512'(tbl[k].eg));
            g = 0;
            for (int i = 0; i < N; i++) if (tbl[k].eg[i]) g = i;
            @(posedge clk);
            #1;
            chk($sformatf("rd_en[%0d]", k), 512'(rd_en), 512'(tbl[k].erd));
            chk($sformatf("outstanding[%0d]", k), 512'(outstanding), 512'(tbl[k].eout));
            chk($sformatf("prv[%0d]", k), 512'(port_resp_valid), 512'(tbl[k].eprv));
            if (tbl[k].erd) begin
                chk($sformatf("rd_mdata[%0d]", k), 512'(rd_mdata),
                    512'((g << 12) | (16'h010 + g)));
                chk($sformatf("rd_addr[%0d]", k), 512'(rd_addr), 512'(48'(g + 1) << 20));
            end
            if (tbl[k].eprv != 4'h0) begin
                chk($sformatf("ptag[%0d]", k), 512'(port_resp_tag), 512'(tbl[k].rmd[11:0]));
                chk($sformatf("pdata[%0d]", k), port_resp_data, pattern(k));
            end
            chk($sformatf("err[%0d]", k), 512'(err), 512'(0));
        end

        // Out-of-range ID on the 3-port instance is dropped and flagged.
        @(negedge clk);
        req_valid = '0; resp_valid = 1'b0; rd_available = 1'b0;
        b_rsp_valid = 1'b1; b_rsp_mdata = 16'h3123; b_rsp_data = pattern(100);
        @(posedge clk);
        #1;
        chk("id3_prv", 512'(b_prv), 512'(0));
        chk("id3_err", 512'(b_err), 512'(1));
        chk("id3_out", 512'(b_out), 512'(0));
        @(negedge clk);
        b_rsp_valid = 1'b0;
        @(posedge clk);
        #1 chk("id3_err_sticky", 512'(b_err), 512'(1));

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("err_cleared", 512'(b_err), 512'(0));

        // Response to a port with nothing outstanding: still delivered, counter stays 0.
        b_rsp_valid = 1'b1; b_rsp_mdata = 16'h0456; b_rsp_data = pattern(200);
        @(posedge clk);
        #1;
        chk("zero_prv", 512'(b_prv), 512'(3'b001));
        chk("zero_tag", 512'(b_ptag), 512'(12'h456));
        chk("zero_data", b_prd, pattern(200));
        chk("zero_err", 512'(b_err), 512'(1));
        chk("zero_out", 512'(b_out), 512'(0));
        @(negedge clk);
        b_rsp_valid = 1'b0;

        // Main instance carries state from the table; reset must clear everything.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk_reset_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rd_req_arbiter.md
Name: rd_req_arbiter

Overview:
- Shares the single CCI-P read-request channel (c0Tx) among NUM_REQ accelerator read ports inside the AFU manager.
- Round-robin arbitration, one request per cycle, gated by channel back-pressure, the per-port enable mask and a per-port outstanding-request limit.
- Stamps each issued request's mdata with the port ID.
- Routes c0Rx read responses back to the owning port by decoding that ID.

Parameters:
- NUM_REQ, 4: number of requesting ports, 2..16.
- ADDR_W, 48: byte-address width.
- MDATA_W, 16: CCI mdata width.
- TAG_W, 12: per-port tag width carried opaquely in mdata. Requires ID_W+TAG_W <= MDATA_W, where ID_W = max(1, clog2(NUM_REQ)).
- MAX_OUT, 32: outstanding reads allowed per port. Counter width CNT_W = clog2(MAX_OUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- port_en  in  NUM_REQ  per-port enable (start mask)
- req_valid  in  NUM_REQ  port i has a request
- req_addr  in  NUM_REQ*ADDR_W  packed byte addresses, port i at [i*ADDR_W +: ADDR_W]
- req_tag  in  NUM_REQ*TAG_W  packed port tags
- req_grant  out  NUM_REQ  one-hot, combinational; request accepted this cycle
- rd_available  in  1  ~c0TxAlmFull
- rd_en  out  1  registered issue strobe
- rd_addr  out  ADDR_W  registered byte address
- rd_mdata  out  MDATA_W  {zero pad, ID, tag}
- resp_valid  in  1  c0Rx read response valid
- resp_data  in  512  response line
- resp_mdata  in  MDATA_W  response mdata
- port_resp_valid  out  NUM_REQ  one-hot, registered
- port_resp_data  out  512  registered, shared by all ports
- port_resp_tag  out  TAG_W  registered, shared by all ports
- outstanding  out  NUM_REQ*CNT_W  per-port in-flight counts
- idle  out  1  all counts zero and rd_en low
- err  out  1  sticky protocol error

Behaviour:
- Eligibility: port i is eligible iff req_valid[i] & port_en[i] & (cnt[i] < MAX_OUT).
- Grant:
  - Only when rd_available=1.
  - Goes to the first eligible port searching from rr_ptr upward, modulo NUM_REQ.
  - At most one grant per cycle; the port sees valid/grant as a same-cycle handshake.
  - req_grant is all-zero when rd_available=0 or no port is eligible.
- Pointer: after a grant to port g, rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds. Reset value 0.
- Issue latency: a grant in cycle N drives, in cycle N+1:
  - rd_en=1
  - rd_addr = the granted address
  - rd_mdata = {0, g[ID_W-1:0], tag}
  - When there is no grant, rd_en=0 and addr/mdata hold their previous values.
- Counters:
  - cnt[i] increments on a grant to i.
  - cnt[i] decrements on a response whose decoded ID equals i.
  - Grant and response to the same port in the same cycle: count unchanged.
  - Counters never exceed MAX_OUT, guaranteed by the eligibility rule.
- Response routing: a response in cycle N drives, in cycle N+1:
  - port_resp_valid[id]=1
  - port_resp_data = resp_data
  - port_resp_tag = resp_mdata[TAG_W-1:0]
  - No stall path exists; ports must always accept responses.
- Errors (set err; err stays 1 until reset):
  - Response ID >= NUM_REQ: response dropped, no counter change.
  - Response to a port whose cnt=0: response still delivered, counter stays 0.
- Disable: clearing port_en[i] blocks new grants only. In-flight responses still route and decrement.
- Reset (sync): rd_en=0, rd_addr=0, rd_mdata=0, port_resp_valid=0, port_resp_data=0, port_resp_tag=0, all counters=0, rr_ptr=0, err=0, idle=1.
  - Responses arriving after a mid-operation reset are treated as errors only if they violate the rules above.
- idle is combinational from counters and rd_en.

Decomposition:
- Package rd_arb_pkg holds:
  - ID_W and CNT_W derivation functions
  - mdata pack/unpack functions
  - default parameter constants
- One sub-module, rr_arbiter: generic NUM_REQ round-robin picker. Inputs: eligible vector, advance strobe. Outputs: one-hot grant, pointer.
- Counters and routing stay in the top module.

Test Plan:
- Ports 0-3 all valid, enabled, rd_available=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; rd_en one cycle after each grant; rd_mdata ID field matches the granted port.
- rd_available=0 for 3 cycles with all ports valid -> req_grant=0 and rd_en=0 throughout; first grant after release goes to rr_ptr (unchanged).
- MAX_OUT=2, port 1 alone valid with no responses -> two grants, then blocked with outstanding[1]=2; one response with ID 1 -> grant resumes the following cycle.
- Response with mdata={ID 2, tag 0xABC} and data pattern D -> next cycle port_resp_valid=4'b0100, port_resp_tag=0xABC, port_resp_data=D, cnt[2] decremented.
- Same-cycle grant to port 0 and response for port 0 with cnt[0]=1 -> cnt[0] stays 1.
- Response with ID 3 when NUM_REQ=3 -> no port_resp_valid, err=1 until reset. Response to a port with count 0 -> delivered, err=1. Assert reset -> err=0, idle=1, all outputs zero.
